// File: rtl/stream_comparator.sv
// stream_comparator
//   Compares two WIDTH-bit operands (unsigned or two's complement, chosen per
//   pair by signed_mode) behind a valid/ready handshake. The result is held
//   in a one-entry output register, so the block can accept a new pair every
//   cycle. Three saturating event counters track how many accepted pairs were
//   greater, lesser or equal.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for a, b, signed_mode
//   a, b                operands (WIDTH bits)
//   signed_mode         1: two's complement compare, 0: unsigned compare
//   out_valid/out_ready output handshake for greater/lesser/equal
//   greater/lesser/equal one-hot result while out_valid=1, all 0 otherwise
//   clr                 synchronous clear of the event counters
//   gt_count/lt_count/eq_count  saturating event counters (CNT_W bits)
module stream_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             lesser,
  output logic             equal,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count
);

  logic accept;
  logic cmp_gt;
  logic cmp_lt;
  logic cmp_eq;

  // The output register can take a new result when empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    cmp_eq = (a == b);
    cmp_gt = 1'b0;
    cmp_lt = 1'b0;
    if (signed_mode) begin
      cmp_gt = $signed(a) > $signed(b);
      cmp_lt = $signed(a) < $signed(b);
    end else begin
      cmp_gt = a > b;
      cmp_lt = a < b;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Result register: load on accept, clear flags when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      greater   <= 1'b0;
      lesser    <= 1'b0;
      equal     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      greater   <= cmp_gt;
      lesser    <= cmp_lt;
      equal     <= cmp_eq;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      greater   <= 1'b0;
      lesser    <= 1'b0;
      equal     <= 1'b0;
    end
  end

  // Event counters: clr takes priority over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_count <= '0;
      lt_count <= '0;
      eq_count <= '0;
    end else if (clr) begin
      gt_count <= '0;
      lt_count <= '0;
      eq_count <= '0;
    end else if (accept) begin
      if (cmp_gt) gt_count <= sat_inc(gt_count);
      if (cmp_lt) lt_count <= sat_inc(lt_count);
      if (cmp_eq) eq_count <= sat_inc(eq_count);
    end
  end

endmodule

// File: tb/tb_stream_comparator.sv
module tb_stream_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_mode;
  logic        out_ready;
  logic        clr;

  logic        in_ready, out_valid, greater, lesser, equal;
  logic [15:0] gt_count, lt_count, eq_count;

  logic        in_ready4, out_valid4, greater4, lesser4, equal4;
  logic [3:0]  gt_count4, lt_count4, eq_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_comparator #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .greater(greater), .lesser(lesser), .equal(equal),
    .clr(clr), .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count)
  );

  stream_comparator #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid4),
    .out_ready(out_ready), .greater(greater4), .lesser(lesser4), .equal(equal4),
    .clr(clr), .gt_count(gt_count4), .lt_count(lt_count4), .eq_count(eq_count4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic       gt;
    logic       lt;
    logic       eq;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic sm, input logic ordy, input logic c);
    in_valid    = v;
    a           = aa;
    b           = bb;
    signed_mode = sm;
    out_ready   = ordy;
    clr         = c;
  endtask

  int exp_gt, exp_lt, exp_eq;

  initial begin
    vecs[0]  = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h01, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'hFE, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h81, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'h81, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset with a pair offered: nothing may be accepted.
    rst_n = 1'b0;
    drive(1'b1, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {greater, lesser, equal}, 0);
    chk("rst_counts", {gt_count, lt_count, eq_count}, 0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk("idle_out_valid", out_valid, 0);

    // Table: back-to-back accepts with out_ready held high.
    exp_gt = 0; exp_lt = 0; exp_eq = 0;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sm, 1'b1, 1'b0);
      step();
      exp_gt += int'(vecs[i].gt);
      exp_lt += int'(vecs[i].lt);
      exp_eq += int'(vecs[i].eq);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_flags", i), {greater, lesser, equal},
          {vecs[i].gt, vecs[i].lt, vecs[i].eq});
      chk($sformatf("vec%0d_counts", i), {gt_count, lt_count, eq_count},
          {16'(exp_gt), 16'(exp_lt), 16'(exp_eq)});
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_flags", {greater, lesser, equal}, 0);

    // Backpressure: held result must not change or be counted.
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    chk("clr_counts", {gt_count, lt_count, eq_count}, 0);
    drive(1'b1, 8'd5, 8'd3, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_first_greater", greater, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd1, 8'd9, logic'(i % 2), 1'b0, 1'b0);
      #1;
      chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_hold_flags", {out_valid, greater, lesser, equal}, 4'b1100);
      chk("bp_lt_count", lt_count, 0);
    end
    drive(1'b1, 8'd1, 8'd9, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("bp_second_lesser", {out_valid, greater, lesser, equal}, 4'b1010);
    chk("bp_counts", {gt_count, lt_count}, {16'd1, 16'd1});
    step();
    chk("bp_drained", out_valid, 0);

    // Saturation on the 4-bit counter instance.
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'd9, 8'd2, 1'b0, 1'b1, 1'b0);
      step();
      if (i == 14) chk("sat_reach15", gt_count4, 4'd15);
    end
    chk("sat_gt4", gt_count4, 4'd15);
    chk("sat_lt_eq4", {lt_count4, eq_count4}, 0);
    chk("nosat_gt16", gt_count, 16'd20);

    // clr beats a same-cycle accept, flags still register.
    drive(1'b1, 8'h33, 8'h33, 1'b1, 1'b1, 1'b0);
    step();
    chk("pre_clr_eq", eq_count, 16'd1);
    drive(1'b1, 8'h44, 8'h44, 1'b0, 1'b1, 1'b1);
    step();
    chk("clr_accept_counts", {gt_count, lt_count, eq_count}, 0);
    chk("clr_accept_flags", {out_valid, greater, lesser, equal}, 4'b1001);

    // Asynchronous reset mid-transfer.
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'd200, 8'd100, 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_state", {out_valid, greater, gt_count}, {1'b1, 1'b1, 16'd7});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_flags", {greater, lesser, equal}, 0);
    chk("async_rst_counts", {gt_count, lt_count, eq_count}, 0);
    chk("async_rst_in_ready", in_ready, 1);
    step();
    chk("rst_held_valid", out_valid, 0);
    #2 rst_n = 1'b1;
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1, 1'b0);
    step();
    chk("post_rst_accept", {out_valid, greater, lesser, equal}, 4'b1001);
    chk("post_rst_eq_count", eq_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
